// File: rtl/pcie_st_rx_pkt_fifo.sv
// pcie_st_rx_pkt_fifo: AXI-ST RX packet FIFO with cut-through/store-and-forward, packet count and graded halt.
// Optional statistics outputs enabled by PCIE_ST_RX_PKT_FIFO_STATS_EN.
module pcie_st_rx_pkt_fifo #(
  parameter int DATA_W = 256,
  localparam int KEEP_W = DATA_W / 8,
  parameter int DEPTH = 64,
  parameter int HALT_THRESH = 16,
  parameter int STORE_FWD = 0
) (
  input  logic                     axi_st_clk,
  input  logic                     axi_st_areset_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic [KEEP_W-1:0]        s_tkeep,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic [2:0]               halt,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     oversize_err
`ifdef PCIE_ST_RX_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]              pkt_in_cnt,
  output logic [31:0]              pkt_out_cnt,
  output logic [$clog2(DEPTH):0]   level_max
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {HOLD, SEND, OVER} state_t;
  state_t state;
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n, pkt_n, free_n;
  logic [DATA_W+KEEP_W:0] mem [DEPTH];
  logic wr, rd, full_n;
  assign wr = s_tvalid & s_tready;
  assign rd = m_tvalid & m_tready;
  assign {m_tlast, m_tkeep, m_tdata} = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, rd};
  assign level_n = wr_ptr_n - rd_ptr_n;
  assign full_n = (wr_ptr_n ^ rd_ptr_n) == {1'b1, {AW{1'b0}}};
  assign pkt_n = pkt_count + {{AW{1'b0}}, wr & s_tlast} - {{AW{1'b0}}, rd & m_tlast};
  assign free_n = (AW+1)'(DEPTH) - level_n;
  // store-and-forward gates the read side until a whole packet (or an oversize escape) is available
  assign m_tvalid = (wr_ptr != rd_ptr) & (STORE_FWD == 0 || state != HOLD);
  always_ff @(posedge axi_st_clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
  end
  always_ff @(posedge axi_st_clk) begin
    if (!axi_st_areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_count <= '0;
      halt <= '0;
      s_tready <= 1'b0;
      oversize_err <= 1'b0;
      state <= HOLD;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      pkt_count <= pkt_n;
      s_tready <= !full_n;
      halt <= {free_n <= (AW+1)'(2), free_n <= (AW+1)'(HALT_THRESH / 2), free_n <= (AW+1)'(HALT_THRESH)};
      if (STORE_FWD != 0) begin
        state <= state == HOLD ? (pkt_n != '0 ? SEND : full_n ? OVER : HOLD)
               : (rd & m_tlast) ? ((state == SEND && pkt_n != '0) ? SEND : HOLD) : state;
        if (state == HOLD && pkt_n == '0 && full_n) oversize_err <= 1'b1;
      end
    end
  end
`ifdef PCIE_ST_RX_PKT_FIFO_STATS_EN
  always_ff @(posedge axi_st_clk) begin
    if (!axi_st_areset_n) begin
      pkt_in_cnt <= '0;
      pkt_out_cnt <= '0;
      level_max <= '0;
    end else begin
      pkt_in_cnt <= pkt_in_cnt + {31'd0, wr & s_tlast};
      pkt_out_cnt <= pkt_out_cnt + {31'd0, rd & m_tlast};
      level_max <= level_n > level_max ? level_n : level_max;
    end
  end
`endif
endmodule

// File: tb/tb_pcie_st_rx_pkt_fifo.sv
// tb_pcie_st_rx_pkt_fifo: directed + random bench with a queue-based packet model, cut-through and store-and-forward instances.
module tb_pcie_st_rx_pkt_fifo;
  localparam int DW = 64, KW = 8, D = 8, HT = 4, LW = 4;
  typedef logic [DW+KW:0] beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_tvalid [2], s_tready [2], s_tlast [2], m_tvalid [2], m_tready [2], m_tlast [2], oversize_err [2];
  logic [DW-1:0] s_tdata [2], m_tdata [2];
  logic [KW-1:0] s_tkeep [2], m_tkeep [2];
  logic [2:0] halt [2];
  logic [LW-1:0] level [2], pkt_count [2];
`ifdef PCIE_ST_RX_PKT_FIFO_STATS_EN
  logic [31:0] pin [2], pout [2];
  logic [LW-1:0] lmax [2];
`endif
  beat_t q [2][$];
  bit osz_act [2], osz_err_m [2], exp_rdy [2];
  int passed = 0, failed = 0, total = 0;
  int rem [2];

  always #5 clk = ~clk;

  pcie_st_rx_pkt_fifo #(.DATA_W(DW), .DEPTH(D), .HALT_THRESH(HT), .STORE_FWD(0)) u_ct (
    .axi_st_clk(clk), .axi_st_areset_n(rst_n),
    .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]), .s_tkeep(s_tkeep[0]), .s_tlast(s_tlast[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]), .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]),
    .halt(halt[0]), .level(level[0]), .pkt_count(pkt_count[0]), .oversize_err(oversize_err[0])
`ifdef PCIE_ST_RX_PKT_FIFO_STATS_EN
    , .pkt_in_cnt(pin[0]), .pkt_out_cnt(pout[0]), .level_max(lmax[0])
`endif
  );

  pcie_st_rx_pkt_fifo #(.DATA_W(DW), .DEPTH(D), .HALT_THRESH(HT), .STORE_FWD(1)) u_sf (
    .axi_st_clk(clk), .axi_st_areset_n(rst_n),
    .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]), .s_tkeep(s_tkeep[1]), .s_tlast(s_tlast[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]), .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]),
    .halt(halt[1]), .level(level[1]), .pkt_count(pkt_count[1]), .oversize_err(oversize_err[1])
`ifdef PCIE_ST_RX_PKT_FIFO_STATS_EN
    , .pkt_in_cnt(pin[1]), .pkt_out_cnt(pout[1]), .level_max(lmax[1])
`endif
  );

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ntl(int i);
    int n = 0;
    foreach (q[i][j]) n += int'(q[i][j][DW+KW]);
    return n;
  endfunction

  // a packet becomes visible once complete, or immediately while an oversize packet is being flushed
  function automatic bit exp_valid(int i);
    return q[i].size() > 0 && (i == 0 || ntl(i) > 0 || osz_act[i]);
  endfunction

  task automatic check_all(int i);
    int fr;
    beat_t b;
    fr = D - q[i].size();
    chk($sformatf("s_tready%0d", i), s_tready[i], exp_rdy[i]);
    chk($sformatf("m_tvalid%0d", i), m_tvalid[i], exp_valid(i));
    chk($sformatf("level%0d", i), level[i], q[i].size());
    chk($sformatf("pkt_count%0d", i), pkt_count[i], ntl(i));
    chk($sformatf("halt%0d", i), halt[i], {fr <= 2, fr <= HT / 2, fr <= HT});
    chk($sformatf("oversize_err%0d", i), oversize_err[i], osz_err_m[i]);
    if (exp_valid(i)) begin
      b = q[i][0];
      chk($sformatf("m_tdata%0d", i), m_tdata[i], b[DW-1:0]);
      chk($sformatf("m_tkeep%0d", i), m_tkeep[i], b[DW+KW-1:DW]);
      chk($sformatf("m_tlast%0d", i), m_tlast[i], b[DW+KW]);
    end
  endtask

  task automatic tick();
    bit wr [2], rd [2];
    beat_t b;
    for (int i = 0; i < 2; i++) begin
      wr[i] = s_tvalid[i] && exp_rdy[i];
      rd[i] = m_tready[i] && exp_valid(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        q[i].delete();
        osz_act[i] = 0;
        osz_err_m[i] = 0;
        exp_rdy[i] = 0;
      end else begin
        if (rd[i]) begin
          b = q[i].pop_front();
          if (b[DW+KW]) osz_act[i] = 0;
        end
        if (wr[i]) q[i].push_back({s_tlast[i], s_tkeep[i], s_tdata[i]});
        if (i == 1 && !osz_act[i] && q[i].size() == D && ntl(i) == 0) begin
          osz_act[i] = 1;
          osz_err_m[i] = 1;
        end
        exp_rdy[i] = q[i].size() < D;
      end
    end
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic drv(int i, bit v, logic [DW-1:0] d, logic [KW-1:0] k, bit l, bit r);
    s_tvalid[i] = v;
    s_tdata[i] = d;
    s_tkeep[i] = k;
    s_tlast[i] = l;
    m_tready[i] = r;
  endtask

  task automatic idle();
    drv(0, 0, '0, '0, 0, 0);
    drv(1, 0, '0, '0, 0, 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int n, c;
    idle();
    rst_n = 0;
    tick();
    tick();
    chk("rst_s_tready", s_tready[0], 0);
    rst_n = 1;
    tick();
    chk("release_s_tready", s_tready[0], 1);
    // cut-through single packet
    for (int j = 0; j < 3; j++) begin
      drv(0, 1, 64'hA0 + 64'(j), j == 2 ? 8'h0F : 8'hFF, j == 2, 1);
      tick();
      if (j == 0) chk("ct_first_visible", m_tdata[0], 64'hA0);
    end
    idle();
    m_tready[0] = 1;
    repeat (3) tick();
    chk("ct_pkt_drained", pkt_count[0], 0);
    // fill to full with reads stalled
    for (int j = 0; j < 10; j++) begin
      drv(0, 1, rnd(), 8'hFF, j == 4, 0);
      tick();
    end
    chk("full_level", level[0], 8);
    chk("full_halt", halt[0], 3'b111);
    chk("full_s_tready", s_tready[0], 0);
    idle();
    m_tready[0] = 1;
    tick();
    chk("read_full_s_tready", s_tready[0], 1);
    chk("read_full_level", level[0], 7);
    repeat (3) tick();
    chk("level4", level[0], 4);
    drv(0, 1, rnd(), 8'h5A, 1, 1);
    tick();
    chk("simul_level", level[0], 4);
    chk("simul_pkt", pkt_count[0], 1);
    idle();
    m_tready[0] = 1;
    repeat (6) tick();
    // store-and-forward: nothing leaves until tlast
    for (int j = 0; j < 5; j++) begin
      drv(1, 1, rnd(), 8'hFF, 0, 1);
      tick();
    end
    chk("sf_hold_valid", m_tvalid[1], 0);
    drv(1, 1, rnd(), 8'h03, 1, 1);
    tick();
    chk("sf_release_valid", m_tvalid[1], 1);
    idle();
    m_tready[1] = 1;
    n = 0;
    for (int j = 0; j < 8; j++) begin
      if (m_tvalid[1]) n++;
      tick();
    end
    chk("sf_beats_out", n, 6);
    // oversize packet escapes the deadlock
    n = 0;
    c = 0;
    while (c < 40 && n < 12) begin
      drv(1, 1, rnd(), 8'hFF, n == 11, n >= 8);
      if (exp_rdy[1]) n++;
      tick();
      c++;
    end
    chk("osz_accepted", n, 12);
    chk("osz_err", oversize_err[1], 1);
    idle();
    m_tready[1] = 1;
    repeat (14) tick();
    chk("osz_drained", level[1], 0);
    drv(1, 1, rnd(), 8'hFF, 0, 1);
    tick();
    chk("osz_back_hold", m_tvalid[1], 0);
    drv(1, 1, rnd(), 8'hFF, 1, 1);
    tick();
    idle();
    m_tready[1] = 1;
    repeat (3) tick();
    // random traffic on both instances
    rem[0] = $urandom_range(1, 6);
    rem[1] = $urandom_range(1, 6);
    for (int k = 0; k < 600; k++) begin
      bit acc [2];
      for (int i = 0; i < 2; i++) begin
        drv(i, $urandom_range(0, 3) < (k < 300 ? 3 : 1), rnd(), KW'($urandom), rem[i] == 1,
            $urandom_range(0, 3) < (k < 300 ? 1 : 3));
        acc[i] = s_tvalid[i] && exp_rdy[i];
      end
      tick();
      for (int i = 0; i < 2; i++)
        if (acc[i]) rem[i] = rem[i] == 1 ? $urandom_range(1, 6) : rem[i] - 1;
    end
    idle();
    m_tready[0] = 1;
    m_tready[1] = 1;
    repeat (20) tick();
    // reset in the middle of a packet
    for (int j = 0; j < 3; j++) begin
      drv(0, 1, rnd(), 8'hFF, 0, 0);
      tick();
    end
    rst_n = 0;
    idle();
    tick();
    chk("mid_rst_level", level[0], 0);
    chk("mid_rst_valid", m_tvalid[0], 0);
    chk("mid_rst_halt", halt[0], 0);
    rst_n = 1;
    tick();
    chk("post_rst_s_tready", s_tready[0], 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
